jk_cmd_sequencer: RTL

Command-driven stimulus stage that sits directly upstream of the `jk_ff` flip-flop and drives its J and K inputs. It accepts {J,K} commands with a per-command hold duration over a valid/ready interface and buffers them in a DEPTH-entry FIFO. It plays the commands out cycle-accurately and keeps a reference model of Q. It compares the flip-flop's Q against that model and raises a sticky mismatch flag.

---
 rtl/jk_cmd_sequencer_if.sv | 13 +
 rtl/jk_cmd_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer_if.sv
// Command channel into jk_cmd_sequencer: one {J,K} command plus its hold
// count, transferred when cmd_valid and cmd_ready are both high.
interface jk_cmd_sequencer_if #(
  parameter int HOLD_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_jk;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, cmd_jk, cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, cmd_jk, cmd_hold, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Buffers {J,K} commands, plays them onto a downstream jk_ff for their hold
// durations, and checks the returned Q against an internal model.
module jk_cmd_sequencer #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jk_cmd_sequencer_if.slave      cmd,
  output logic                   J,
  output logic                   K,
  input  logic                   q_in,
  output logic                   q_exp,
  output logic                   synced,
  output logic                   mismatch,
  input  logic                   clr_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]       LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);

  typedef enum logic {IDLE, APPLY} state_t;

  typedef struct packed {
    logic [1:0]        jk;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              push, pop, empty, last;
  state_t            state, state_nxt;

  assign empty         = (level == '0);
  assign cmd.cmd_ready = (level != LVL_FULL);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign head          = mem[rd_ptr];
  assign last          = (hold_cnt == CNT_ONE);

  // NOTE: the storage array carries no reset; emptiness is tracked by level
  // and the pointers, so stale entries are never read after a reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd.cmd_jk, cmd.cmd_hold};
  end

  // NOTE: sequential state is always written with <= so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty)        state_nxt = APPLY;
      APPLY:   if (last && empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    busy = 1'b0;
    case (state)
      IDLE: begin
        pop  = !empty;
        busy = !empty;
      end
      APPLY: begin
        pop  = last && !empty;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // A pop at the last cycle of a window loads the next command directly,
  // giving back-to-back windows; hold 0 is promoted to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      J        <= 1'b0;
      K        <= 1'b0;
      hold_cnt <= '0;
    end else if (pop) begin
      {J, K}   <= head.jk;
      hold_cnt <= (head.hold == '0) ? CNT_ONE : head.hold;
    end else if (state == APPLY) begin
      if (last) begin
        J        <= 1'b0;
        K        <= 1'b0;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt - CNT_ONE;
      end
    end
  end

  // Model samples the same J/K the flip-flop sees at this edge; the compare
  // uses pre-edge synced so the unknown power-up Q is never checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_exp    <= 1'b0;
      synced   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   q_exp <= 1'b0;
        2'b10:   q_exp <= 1'b1;
        2'b11:   q_exp <= ~q_exp;
        default: q_exp <= q_exp;
      endcase
      if (J ^ K) synced <= 1'b1;
      if (clr_err)                      mismatch <= 1'b0;
      else if (synced && q_in != q_exp) mismatch <= 1'b1;
    end
  end

endmodule
